dmem_responder: RTL and testbench

- Data-memory responder for the KGP-miniRISC core: the memory end of the CPU load/store interface.
- The CPU datapath acts as initiator, issuing one word request at a time over a valid/ready request channel.
- This block stores words in an internal array, adds a parameterised wait-state latency, and returns read data or status over a valid/ready response channel.
- Intended to replace the zero-latency data memory so the core can be validated against realistic stalls.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the KGP-miniRISC core load/store interface.
// Accepts one word request at a time. After LATENCY wait states it commits the
// request: a store writes the array, a load reads it. The result is then held on
// the response channel until the initiator takes it.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  initiator presents a request
//   req_ready  responder can accept a request (only in idle, out of reset)
//   req_we     1 = store, 0 = load
//   req_addr   byte address; word index is req_addr[ADDR_W+1:2]
//   req_wdata  store data
//   rsp_valid  response available
//   rsp_ready  initiator takes the response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    address out of range
module dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned Words = 1 << ADDR_W;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
    $error("dmem_responder: ADDR_W must be within 1..29");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                oor_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mem [Words];

  logic accept;
  logic commit;
  logic req_oor;
  logic unused_addr_lsb;

  // Byte offset is ignored; the word is always returned whole.
  assign unused_addr_lsb = ^req_addr[1:0];
  assign req_oor         = |req_addr[31:ADDR_W+2];

  // Gated with rst so ready stays low while reset is held, even though the
  // state register already reads idle.
  assign req_ready = (state_q == StIdle) && rst;
  assign accept    = req_valid && req_ready;
  // Commit edge: the last wait edge, LATENCY edges after the accept edge.
  assign commit    = (state_q == StWait) && (cnt_q == 4'd0);

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          if (oor_q) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (we_q) begin
            rdata_d = '0;
          end else begin
            // Read sees the array before any write at this edge.
            rdata_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        oor_q   <= req_oor;
      end
    end
  end

  // Array is not reset; a store aborted by reset never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && we_q && !oor_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder. Main instance uses
// LATENCY=2; two extra instances (LATENCY=1 and 5) check response timing.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        v1, rdy1, rv1, err1;
  logic [31:0] unused_rd1;
  logic        v5, rdy5, rv5, err5;
  logic [31:0] unused_rd5;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic ready_leak = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(1)) u_l1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v1),
    .req_ready (rdy1),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rv1),
    .rsp_ready (1'b1),
    .rsp_rdata (unused_rd1),
    .rsp_err   (err1)
  );

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(5)) u_l5 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v5),
    .req_ready (rdy5),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rv5),
    .rsp_ready (1'b1),
    .rsp_rdata (unused_rd5),
    .rsp_err   (err5)
  );

  // Called at a negedge. Returns at the first negedge with rsp_valid high;
  // lat = rising edges from the accept edge to that point.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat);
    int n;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 30) begin
      if (req_ready) ready_leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (n >= 20) lat = 99;
    rd  = rsp_rdata;
    err = rsp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          n;
    int          prev_acc;
    int          acc;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; v1 = 1'b0; v5 = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $error("FAIL reset_req_ready: observed=%0h expected=0", req_ready);
    end
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $error("FAIL reset_rsp_valid: observed=%0h expected=0", rsp_valid);
    end
    total++;
    if (rsp_rdata !== 32'h0) begin
      bad++; $error("FAIL reset_rsp_rdata: observed=%0h expected=0", rsp_rdata);
    end
    total++;
    if (rsp_err !== 1'b0) begin
      bad++; $error("FAIL reset_rsp_err: observed=%0h expected=0", rsp_err);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $error("FAIL idle_req_ready: observed=%0h expected=1", req_ready);
    end

    // Store then load
    rsp_ready = 1'b1;
    xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, err, lat);
    total++;
    if (lat !== 2) begin
      bad++; $error("FAIL store_latency: observed=%0d expected=2", lat);
    end
    total++;
    if (rd !== 32'h0) begin
      bad++; $error("FAIL store_rdata: observed=%0h expected=0", rd);
    end
    total++;
    if (err !== 1'b0) begin
      bad++; $error("FAIL store_err: observed=%0h expected=0", err);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $error("FAIL post_hs_rsp_valid: observed=%0h expected=0", rsp_valid);
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $error("FAIL post_hs_req_ready: observed=%0h expected=1", req_ready);
    end

    xact(1'b0, 32'h0000_0010, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin
      bad++; $error("FAIL load_10_rdata: observed=%0h expected=deadbeef", rd);
    end
    total++;
    if (lat !== 2) begin
      bad++; $error("FAIL load_10_latency: observed=%0d expected=2", lat);
    end
    @(negedge clk);
    xact(1'b0, 32'h0000_0013, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin
      bad++; $error("FAIL load_13_rdata: observed=%0h expected=deadbeef", rd);
    end
    @(negedge clk);
    total++;
    if (ready_leak !== 1'b0) begin
      bad++; $error("FAIL ready_low_while_busy: observed=%0h expected=0", ready_leak);
    end

    // Pre-write words used by later steps
    xact(1'b1, 32'h0000_0020, 32'h1111_1111, rd, err, lat);
    @(negedge clk);
    xact(1'b1, 32'h0000_0000, 32'hCAFE_0000, rd, err, lat);
    @(negedge clk);

    // Out of range store must not alias onto word 0
    xact(1'b1, 32'h0000_1000, 32'h1234_5678, rd, err, lat);
    total++;
    if (err !== 1'b1) begin
      bad++; $error("FAIL oor_err: observed=%0h expected=1", err);
    end
    total++;
    if (rd !== 32'h0) begin
      bad++; $error("FAIL oor_rdata: observed=%0h expected=0", rd);
    end
    @(negedge clk);
    total++;
    if (rsp_err !== 1'b0) begin
      bad++; $error("FAIL oor_err_cleared: observed=%0h expected=0", rsp_err);
    end
    xact(1'b0, 32'h0000_0000, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'hCAFE_0000) begin
      bad++; $error("FAIL no_alias_rdata: observed=%0h expected=cafe0000", rd);
    end
    total++;
    if (err !== 1'b0) begin
      bad++; $error("FAIL no_alias_err: observed=%0h expected=0", err);
    end
    @(negedge clk);

    // Backpressure: response held 4 cycles, a stray store pulse is ignored
    rsp_ready = 1'b0;
    xact(1'b0, 32'h0000_0010, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin
      bad++; $error("FAIL bp_first_rdata: observed=%0h expected=deadbeef", rd);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        req_we = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'h0BAD_0BAD; req_valid = 1'b1;
      end
      @(negedge clk);
      req_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1) begin
        bad++; $error("FAIL bp_rsp_valid: observed=%0h expected=1", rsp_valid);
      end
      total++;
      if (rsp_rdata !== 32'hDEAD_BEEF) begin
        bad++; $error("FAIL bp_rsp_rdata: observed=%0h expected=deadbeef", rsp_rdata);
      end
      total++;
      if (req_ready !== 1'b0) begin
        bad++; $error("FAIL bp_req_ready: observed=%0h expected=0", req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $error("FAIL bp_release_rsp_valid: observed=%0h expected=0", rsp_valid);
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $error("FAIL bp_release_req_ready: observed=%0h expected=1", req_ready);
    end
    xact(1'b0, 32'h0000_0010, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin
      bad++; $error("FAIL bp_stray_ignored: observed=%0h expected=deadbeef", rd);
    end
    @(negedge clk);

    // Reset during wait aborts an uncommitted store
    req_we = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'hAAAA_5555; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $error("FAIL rst_hold_rsp_valid: observed=%0h expected=0", rsp_valid);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $error("FAIL rst_release_rsp_valid: observed=%0h expected=0", rsp_valid);
      end
    end
    xact(1'b0, 32'h0000_0020, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'h1111_1111) begin
      bad++; $error("FAIL rst_abort_no_write: observed=%0h expected=11111111", rd);
    end
    @(negedge clk);

    // Back-to-back with req_valid held high: store/load alternating to 0x40
    prev_acc = 0;
    req_we = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h0000_5000; req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      if (k > 0) begin
        total++;
        if (acc - prev_acc !== 4) begin
          bad++; $error("FAIL b2b_spacing: observed=%0d expected=4", acc - prev_acc);
        end
      end
      prev_acc = acc;
      // Next request's fields; valid stays asserted throughout
      req_we    = (k % 2 == 1);
      req_wdata = 32'h0000_5000 + 32'(k + 1);
      n = 0;
      while (!rsp_valid && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (k % 2 == 1) begin
        total++;
        if (rsp_rdata !== 32'h0000_5000 + 32'(k - 1)) begin
          bad++; $error("FAIL b2b_load_rdata: observed=%0h expected=%0h", rsp_rdata,
                        32'h0000_5000 + 32'(k - 1));
        end
      end else begin
        total++;
        if (rsp_rdata !== 32'h0) begin
          bad++; $error("FAIL b2b_store_rdata: observed=%0h expected=0", rsp_rdata);
        end
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // LATENCY=1 instance
    req_we = 1'b0; req_addr = 32'h0000_0000;
    total++;
    if (rdy1 !== 1'b1) begin
      bad++; $error("FAIL l1_idle_ready: observed=%0h expected=1", rdy1);
    end
    v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    total++;
    if (rdy1 !== 1'b0) begin
      bad++; $error("FAIL l1_busy_ready: observed=%0h expected=0", rdy1);
    end
    lat = 0;
    while (!rv1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 1) begin
      bad++; $error("FAIL l1_latency: observed=%0d expected=1", lat);
    end
    total++;
    if (err1 !== 1'b0) begin
      bad++; $error("FAIL l1_err: observed=%0h expected=0", err1);
    end

    // LATENCY=5 instance
    total++;
    if (rdy5 !== 1'b1) begin
      bad++; $error("FAIL l5_idle_ready: observed=%0h expected=1", rdy5);
    end
    v5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v5 = 1'b0;
    total++;
    if (rdy5 !== 1'b0) begin
      bad++; $error("FAIL l5_busy_ready: observed=%0h expected=0", rdy5);
    end
    lat = 0;
    while (!rv5 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 5) begin
      bad++; $error("FAIL l5_latency: observed=%0d expected=5", lat);
    end
    total++;
    if (err5 !== 1'b0) begin
      bad++; $error("FAIL l5_err: observed=%0h expected=0", err5);
    end
    @(negedge clk);
    total++;
    if (rdy5 !== 1'b1) begin
      bad++; $error("FAIL l5_back_idle: observed=%0h expected=1", rdy5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
